// File: rtl/udma_filter_sched_if.sv
// Bus bundle for the uDMA filter sequencer: latched filter/channel config in,
// TX/RX address request channels and status out.
interface udma_filter_sched_if #(
  parameter int L2_AWIDTH_NOAL = 15,
  parameter int TRANS_SIZE     = 15
);
  logic                                cfg_filter_start_i;
  logic                                cfg_filter_abort_i;
  logic [2:0]                          cfg_filter_mode_i;
  logic [1:0][L2_AWIDTH_NOAL-1:0]      cfg_tx_start_addr_i;
  logic [1:0][1:0]                     cfg_tx_datasize_i;
  logic [1:0][1:0]                     cfg_tx_mode_i;
  logic [1:0][TRANS_SIZE-1:0]          cfg_tx_len0_i;
  logic [1:0][TRANS_SIZE-1:0]          cfg_tx_len1_i;
  logic [1:0][TRANS_SIZE-1:0]          cfg_tx_len2_i;
  logic [L2_AWIDTH_NOAL-1:0]           cfg_rx_start_addr_i;
  logic [1:0]                          cfg_rx_datasize_i;
  logic [1:0]                          cfg_rx_mode_i;
  logic [TRANS_SIZE-1:0]               cfg_rx_len0_i;
  logic [TRANS_SIZE-1:0]               cfg_rx_len1_i;
  logic [TRANS_SIZE-1:0]               cfg_rx_len2_i;
  logic [1:0]                          tx_req_o;
  logic [1:0][L2_AWIDTH_NOAL-1:0]      tx_addr_o;
  logic [1:0][1:0]                     tx_datasize_o;
  logic [1:0]                          tx_gnt_i;
  logic                                rx_req_o;
  logic [L2_AWIDTH_NOAL-1:0]           rx_addr_o;
  logic [1:0]                          rx_datasize_o;
  logic                                rx_gnt_i;
  logic                                busy_o;
  logic                                done_o;

  modport slave (
    input  cfg_filter_start_i, cfg_filter_abort_i, cfg_filter_mode_i,
    input  cfg_tx_start_addr_i, cfg_tx_datasize_i, cfg_tx_mode_i,
    input  cfg_tx_len0_i, cfg_tx_len1_i, cfg_tx_len2_i,
    input  cfg_rx_start_addr_i, cfg_rx_datasize_i, cfg_rx_mode_i,
    input  cfg_rx_len0_i, cfg_rx_len1_i, cfg_rx_len2_i,
    input  tx_gnt_i, rx_gnt_i,
    output tx_req_o, tx_addr_o, tx_datasize_o,
    output rx_req_o, rx_addr_o, rx_datasize_o,
    output busy_o, done_o
  );

  modport master (
    output cfg_filter_start_i, cfg_filter_abort_i, cfg_filter_mode_i,
    output cfg_tx_start_addr_i, cfg_tx_datasize_i, cfg_tx_mode_i,
    output cfg_tx_len0_i, cfg_tx_len1_i, cfg_tx_len2_i,
    output cfg_rx_start_addr_i, cfg_rx_datasize_i, cfg_rx_mode_i,
    output cfg_rx_len0_i, cfg_rx_len1_i, cfg_rx_len2_i,
    output tx_gnt_i, rx_gnt_i,
    input  tx_req_o, tx_addr_o, tx_datasize_o,
    input  rx_req_o, rx_addr_o, rx_datasize_o,
    input  busy_o, done_o
  );
endinterface

// File: rtl/udma_filter_sched.sv
// uDMA filter sequencer: latches channel config on start and walks linear/2D
// address patterns for TX0, TX1 and RX, one beat per grant per channel.
module udma_filter_sched_ch #(
  parameter int AW = 15,
  parameter int TS = 15
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          en_i,
  input  logic [AW-1:0] cfg_addr_i,
  input  logic [1:0]    cfg_ds_i,
  input  logic [1:0]    cfg_mode_i,
  input  logic [TS-1:0] cfg_len0_i,
  input  logic [TS-1:0] cfg_len1_i,
  input  logic [TS-1:0] cfg_len2_i,
  input  logic          gnt_i,
  output logic          req_o,
  output logic          req_d_o,
  output logic [AW-1:0] addr_o,
  output logic [1:0]    ds_o
);
  logic          req_q, req_d, is2d_q, is2d_d;
  logic [1:0]    ds_q, ds_d;
  logic [TS-1:0] len0_q, len0_d, len1_q, len1_d, len2_q, len2_d;
  logic [TS-1:0] col_q, col_d, row_q, row_d;
  logic [AW-1:0] base_q, base_d;
  logic [TS+1:0] off;
  logic          cfg_2d, cfg_empty, last_col, last_row;

  assign cfg_2d    = (cfg_mode_i == 2'd1);
  assign cfg_empty = (cfg_len0_i == '0) || (cfg_2d && (cfg_len1_i == '0));
  assign last_col  = (col_q == len0_q - 1'b1);
  assign last_row  = !is2d_q || (row_q == len1_q - 1'b1);

  always_comb begin
    case (ds_q)
      2'd0:    off = {2'b00, col_q};
      2'd1:    off = {1'b0, col_q, 1'b0};
      default: off = {col_q, 2'b00};
    endcase
  end

  // linear mode is just the single-row case of the 2D walk
  assign addr_o  = base_q + AW'(off);
  assign req_o   = req_q;
  assign req_d_o = req_d;
  assign ds_o    = ds_q;

  always_comb begin
    req_d  = req_q;
    is2d_d = is2d_q;
    ds_d   = ds_q;
    len0_d = len0_q;
    len1_d = len1_q;
    len2_d = len2_q;
    col_d  = col_q;
    row_d  = row_q;
    base_d = base_q;
    if (start_i) begin
      is2d_d = cfg_2d;
      ds_d   = cfg_ds_i;
      len0_d = cfg_len0_i;
      len1_d = cfg_len1_i;
      len2_d = cfg_len2_i;
      base_d = cfg_addr_i;
      col_d  = '0;
      row_d  = '0;
      req_d  = en_i && !cfg_empty;
    end else if (abort_i) begin
      req_d = 1'b0;
    end else if (req_q && gnt_i) begin
      if (!last_col) begin
        col_d = col_q + 1'b1;
      end else begin
        col_d = '0;
        if (last_row) begin
          req_d = 1'b0;
        end else begin
          row_d  = row_q + 1'b1;
          base_d = base_q + AW'(len2_q);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q  <= 1'b0;
      is2d_q <= 1'b0;
      ds_q   <= '0;
      len0_q <= '0;
      len1_q <= '0;
      len2_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
      base_q <= '0;
    end else begin
      req_q  <= req_d;
      is2d_q <= is2d_d;
      ds_q   <= ds_d;
      len0_q <= len0_d;
      len1_q <= len1_d;
      len2_q <= len2_d;
      col_q  <= col_d;
      row_q  <= row_d;
      base_q <= base_d;
    end
  end
endmodule

module udma_filter_sched #(
  parameter int L2_AWIDTH_NOAL = 15,
  parameter int TRANS_SIZE     = 15
) (
  input logic               clk_i,
  input logic               rst_i,
  udma_filter_sched_if.slave bus
);
  localparam int AW     = L2_AWIDTH_NOAL;
  localparam int TS     = TRANS_SIZE;
  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  state_e state_q, state_d;

  logic                         start_go, abort_go, unused_mode;
  logic [NUM_CH-1:0]            ch_en, ch_gnt, ch_req, ch_req_d;
  logic [NUM_CH-1:0][AW-1:0]    ch_sa, ch_addr;
  logic [NUM_CH-1:0][1:0]       ch_ds, ch_md, ch_ds_o;
  logic [NUM_CH-1:0][TS-1:0]    ch_l0, ch_l1, ch_l2;

  // channel order: [0]=TX0, [1]=TX1, [2]=RX
  assign ch_en  = {bus.cfg_filter_mode_i[1], bus.cfg_filter_mode_i[0], 1'b1};
  assign ch_gnt = {bus.rx_gnt_i, bus.tx_gnt_i};
  assign ch_sa  = {bus.cfg_rx_start_addr_i, bus.cfg_tx_start_addr_i};
  assign ch_ds  = {bus.cfg_rx_datasize_i, bus.cfg_tx_datasize_i};
  assign ch_md  = {bus.cfg_rx_mode_i, bus.cfg_tx_mode_i};
  assign ch_l0  = {bus.cfg_rx_len0_i, bus.cfg_tx_len0_i};
  assign ch_l1  = {bus.cfg_rx_len1_i, bus.cfg_tx_len1_i};
  assign ch_l2  = {bus.cfg_rx_len2_i, bus.cfg_tx_len2_i};
  assign unused_mode = bus.cfg_filter_mode_i[2];

  assign start_go = (state_q == IDLE) && bus.cfg_filter_start_i;
  assign abort_go = (state_q == RUN) && bus.cfg_filter_abort_i;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    udma_filter_sched_ch #(.AW(AW), .TS(TS)) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_go),
      .abort_i    (abort_go),
      .en_i       (ch_en[g]),
      .cfg_addr_i (ch_sa[g]),
      .cfg_ds_i   (ch_ds[g]),
      .cfg_mode_i (ch_md[g]),
      .cfg_len0_i (ch_l0[g]),
      .cfg_len1_i (ch_l1[g]),
      .cfg_len2_i (ch_l2[g]),
      .gnt_i      (ch_gnt[g]),
      .req_o      (ch_req[g]),
      .req_d_o    (ch_req_d[g]),
      .addr_o     (ch_addr[g]),
      .ds_o       (ch_ds_o[g])
    );
  end

  // looking at next-cycle req lets done follow the final grant by one cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.cfg_filter_start_i) state_d = RUN;
      RUN:     if (bus.cfg_filter_abort_i) state_d = IDLE;
               else if (ch_req_d == '0)    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign bus.tx_req_o      = ch_req[1:0];
  assign bus.tx_addr_o     = ch_addr[1:0];
  assign bus.tx_datasize_o = ch_ds_o[1:0];
  assign bus.rx_req_o      = ch_req[2];
  assign bus.rx_addr_o     = ch_addr[2];
  assign bus.rx_datasize_o = ch_ds_o[2];
  assign bus.busy_o        = (state_q == RUN);
  assign bus.done_o        = (state_q == DONE);
endmodule

// File: tb/tb_udma_filter_sched.sv
// Scoreboard bench for udma_filter_sched: per-channel expected address queues
// built from the addressing rules, checked by a monitor on every grant.
module tb_udma_filter_sched;
  localparam int AW = 15;
  localparam int TS = 15;

  typedef struct packed {
    logic [AW-1:0] sa;
    logic [1:0]    ds;
    logic [1:0]    md;
    logic [TS-1:0] l0;
    logic [TS-1:0] l1;
    logic [TS-1:0] l2;
  } chcfg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  udma_filter_sched_if #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS)) bus();
  udma_filter_sched #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_chk = 0, n_pass = 0;
  logic [AW-1:0] expq[3][$];
  logic [1:0]    exp_ds[3];
  int  gcnt[3];
  int  cyc = 0, last_gnt_cyc = -10;
  bit  done_pend = 1'b0;
  int  gnt_mode = 0;
  logic alt = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic get_req(int ch);
    return (ch == 2) ? bus.rx_req_o : bus.tx_req_o[ch];
  endfunction
  function automatic logic get_gnt(int ch);
    return (ch == 2) ? bus.rx_gnt_i : bus.tx_gnt_i[ch];
  endfunction
  function automatic logic [AW-1:0] get_addr(int ch);
    return (ch == 2) ? bus.rx_addr_o : bus.tx_addr_o[ch];
  endfunction
  function automatic logic [1:0] get_ds(int ch);
    return (ch == 2) ? bus.rx_datasize_o : bus.tx_datasize_o[ch];
  endfunction

  task automatic set_gnt(input logic [2:0] g);
    bus.tx_gnt_i = g[1:0];
    bus.rx_gnt_i = g[2];
  endtask

  function automatic int rnd(int lo, int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  function automatic chcfg_t mk(int sa, int ds, int md, int l0, int l1, int l2);
    chcfg_t c;
    c.sa = AW'(sa); c.ds = 2'(ds); c.md = 2'(md);
    c.l0 = TS'(l0); c.l1 = TS'(l1); c.l2 = TS'(l2);
    return c;
  endfunction

  function automatic chcfg_t rand_cfg(int lmin);
    return mk(rnd(0, 32767), rnd(0, 3), rnd(0, 3), rnd(lmin, 5), rnd(lmin, 3), rnd(0, 32767));
  endfunction

  task automatic set_ch(input int ch, input chcfg_t c);
    if (ch == 2) begin
      bus.cfg_rx_start_addr_i = c.sa; bus.cfg_rx_datasize_i = c.ds; bus.cfg_rx_mode_i = c.md;
      bus.cfg_rx_len0_i = c.l0; bus.cfg_rx_len1_i = c.l1; bus.cfg_rx_len2_i = c.l2;
    end else begin
      bus.cfg_tx_start_addr_i[ch] = c.sa; bus.cfg_tx_datasize_i[ch] = c.ds;
      bus.cfg_tx_mode_i[ch] = c.md; bus.cfg_tx_len0_i[ch] = c.l0;
      bus.cfg_tx_len1_i[ch] = c.l1; bus.cfg_tx_len2_i[ch] = c.l2;
    end
  endtask

  // Reference: every beat of a row-major walk, start + row*stride + col*eb, mod 2^AW
  function automatic void push_model(int ch, chcfg_t c, bit en);
    int eb, rows, a;
    exp_ds[ch] = c.ds;
    if (!en) return;
    eb   = (c.ds == 2'd0) ? 1 : (c.ds == 2'd1) ? 2 : 4;
    rows = (c.md == 2'd1) ? int'(c.l1) : 1;
    for (int r = 0; r < rows; r++)
      for (int k = 0; k < int'(c.l0); k++) begin
        a = int'(c.sa) + r * int'(c.l2) + k * eb;
        expq[ch].push_back(a[AW-1:0]);
      end
  endfunction

  task automatic flush();
    for (int ch = 0; ch < 3; ch++) expq[ch].delete();
  endtask

  task automatic scramble();
    logic [31:0] r;
    r = $urandom;
    bus.cfg_filter_mode_i = r[2:0];
    for (int ch = 0; ch < 3; ch++) set_ch(ch, rand_cfg(0));
  endtask

  task automatic apply(input logic [2:0] mode, input chcfg_t c0, input chcfg_t c1,
                       input chcfg_t c2, input bit with_abort);
    @(posedge clk); #1;
    bus.cfg_filter_mode_i = mode;
    set_ch(0, c0); set_ch(1, c1); set_ch(2, c2);
    bus.cfg_filter_start_i = 1'b1;
    bus.cfg_filter_abort_i = with_abort;
    for (int ch = 0; ch < 3; ch++) gcnt[ch] = 0;
    push_model(0, c0, 1'b1);
    push_model(1, c1, mode[0]);
    push_model(2, c2, mode[1]);
    done_pend = 1'b1;
    @(posedge clk); #1;
    bus.cfg_filter_start_i = 1'b0;
    bus.cfg_filter_abort_i = 1'b0;
    scramble();
    chk("busy_after_start", int'(bus.busy_o), 1);
  endtask

  task automatic wait_done();
    int i = 0;
    while (done_pend && i < 3000) begin @(posedge clk); i++; end
    chk("done_seen", int'(done_pend), 0);
    if (done_pend) flush();
    done_pend = 1'b0;
    #1;
    chk("idle_after_done", int'(bus.busy_o), 0);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_req"}, int'({bus.rx_req_o, bus.tx_req_o}), 0);
    chk({nm, "_addr"}, int'(bus.tx_addr_o[0] | bus.tx_addr_o[1] | bus.rx_addr_o), 0);
    chk({nm, "_ds"}, int'({bus.rx_datasize_o, bus.tx_datasize_o}), 0);
    chk({nm, "_busy"}, int'(bus.busy_o), 0);
    chk({nm, "_done"}, int'(bus.done_o), 0);
  endtask

  // grant driver
  always @(posedge clk) begin
    logic [31:0] r;
    #1;
    case (gnt_mode)
      0: set_gnt(3'b111);
      1: begin alt = ~alt; set_gnt({3{alt}}); end
      2: begin r = $urandom; set_gnt(r[2:0]); end
      default: ;
    endcase
  end

  // monitor
  bit            prev_req[3], prev_gnt[3];
  logic [AW-1:0] prev_addr[3];
  always @(negedge clk) begin
    logic [AW-1:0] a, e;
    logic r, g;
    cyc++;
    if (rst) begin
      for (int ch = 0; ch < 3; ch++) begin prev_req[ch] = 1'b0; prev_gnt[ch] = 1'b0; end
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        r = get_req(ch); g = get_gnt(ch); a = get_addr(ch);
        if (r) begin
          if (prev_req[ch] && !prev_gnt[ch]) chk("addr_hold", int'(a), int'(prev_addr[ch]));
          chk("req_expected", int'(expq[ch].size() > 0), 1);
          if (g && expq[ch].size() > 0) begin
            e = expq[ch].pop_front();
            chk("addr", int'(a), int'(e));
            chk("datasize", int'(get_ds(ch)), int'(exp_ds[ch]));
            gcnt[ch]++;
            last_gnt_cyc = cyc;
          end
        end
        prev_req[ch] = r; prev_gnt[ch] = g; prev_addr[ch] = a;
      end
      if (bus.done_o) begin
        chk("done_expected", int'(done_pend), 1);
        chk("done_after_all", expq[0].size() + expq[1].size() + expq[2].size(), 0);
        chk("done_latency", cyc - last_gnt_cyc, 1);
        chk("busy_in_done", int'(bus.busy_o), 0);
        done_pend = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_filter_start_i = 1'b0;
    bus.cfg_filter_abort_i = 1'b0;
    bus.cfg_filter_mode_i  = '0;
    for (int ch = 0; ch < 3; ch++) set_ch(ch, mk(0, 0, 0, 0, 0, 0));
    set_gnt(3'b000);
    gnt_mode = 3;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_outputs_zero("idle");

    // linear TX0 only, word, always granted
    gnt_mode = 0;
    apply(3'b000, mk('h100, 2, 0, 4, 0, 0), rand_cfg(1), rand_cfg(1), 1'b0);
    wait_done();
    chk("lin_beats", gcnt[0], 4);

    // 2D half-words with alternating backpressure
    gnt_mode = 1;
    apply(3'b000, mk('h200, 1, 1, 2, 3, 'h40), rand_cfg(1), rand_cfg(1), 1'b0);
    wait_done();
    chk("2d_beats", gcnt[0], 6);

    // all channels, independent random grants
    gnt_mode = 2;
    apply(3'b011, mk(rnd(0, 32767), 0, 0, 3, 0, 0), mk(rnd(0, 32767), 0, 0, 5, 0, 0),
          mk(rnd(0, 32767), 0, 0, 2, 0, 0), 1'b0);
    wait_done();
    chk("all_tx0_beats", gcnt[0], 3);
    chk("all_tx1_beats", gcnt[1], 5);
    chk("all_rx_beats", gcnt[2], 2);

    // RX enabled with zero length
    gnt_mode = 0;
    apply(3'b010, mk('h300, 0, 0, 3, 0, 0), rand_cfg(1), mk('h400, 0, 0, 0, 2, 0), 1'b0);
    wait_done();
    chk("zero_rx_beats", gcnt[2], 0);

    // address wrap; abort together with start in IDLE must still start
    apply(3'b000, mk('h7FFE, 2, 0, 2, 0, 0), rand_cfg(1), rand_cfg(1), 1'b1);
    wait_done();
    chk("wrap_beats", gcnt[0], 2);

    // abort after 2 of 8 grants
    gnt_mode = 3;
    set_gnt(3'b000);
    apply(3'b000, mk('h1000, 0, 0, 8, 0, 0), rand_cfg(1), rand_cfg(1), 1'b0);
    set_gnt(3'b001);
    repeat (2) begin @(posedge clk); #1; end
    set_gnt(3'b000);
    bus.cfg_filter_abort_i = 1'b1;
    done_pend = 1'b0;
    @(posedge clk); #1;
    bus.cfg_filter_abort_i = 1'b0;
    flush();
    chk("abort_beats", gcnt[0], 2);
    chk("abort_req", int'({bus.rx_req_o, bus.tx_req_o}), 0);
    chk("abort_busy", int'(bus.busy_o), 0);
    repeat (4) begin @(posedge clk); #1; chk("abort_no_done", int'(bus.done_o), 0); end

    // new cfg after abort; a second start in RUN is ignored
    gnt_mode = 1;
    apply(3'b011, mk('h0A0, 1, 0, 8, 0, 0), mk('h5000, 2, 1, 2, 2, 'h100),
          rand_cfg(1), 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    bus.cfg_filter_start_i = 1'b1;
    @(posedge clk); #1;
    bus.cfg_filter_start_i = 1'b0;
    wait_done();
    chk("restart_tx0_beats", gcnt[0], 8);
    chk("restart_tx1_beats", gcnt[1], 4);

    // reset in the middle of a run
    apply(3'b011, mk('h2000, 0, 0, 10, 0, 0), mk('h3000, 0, 0, 10, 0, 0),
          mk('h4000, 0, 0, 10, 0, 0), 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("midrun_reset");
    flush();
    done_pend = 1'b0;
    repeat (3) begin @(negedge clk); chk("reset_no_done", int'(bus.done_o), 0); end
    @(posedge clk); #1;
    rst = 1'b0;

    // randomized runs
    gnt_mode = 2;
    for (int n = 0; n < 10; n++) begin
      logic [31:0] m;
      m = $urandom;
      apply(m[2:0], rand_cfg(1), rand_cfg(0), rand_cfg(0), 1'b0);
      wait_done();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/udma_filter_sched.md
Name: udma_filter_sched

Overview:
- Sequencer for the uDMA filter datapath.
- On a start pulse from the filter configuration block it latches the channel configuration and generates L2 address requests for the two operand read channels (TX0, TX1) and the result write channel (RX).
- Handles linear and 2D addressing, counts granted beats per channel, and pulses done when all enabled channels complete.
- Sits between the filter config registers and the uDMA TX/RX channel ports of the filter.

Parameters:
L2_AWIDTH_NOAL, 15, L2 address width (byte addresses, non-aligned)
TRANS_SIZE, 15, width of length/count/stride fields

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
cfg_filter_start_i  in  1  start pulse
cfg_filter_abort_i  in  1  abort pulse
cfg_filter_mode_i  in  3  bit0 = TX1 enable, bit1 = RX enable, bit2 ignored
cfg_tx_start_addr_i  in  2xL2_AWIDTH_NOAL  per-TX start address
cfg_tx_datasize_i  in  2x2  0 = byte, 1 = half, 2/3 = word
cfg_tx_mode_i  in  2x2  0 = linear, 1 = 2D, 2/3 = linear
cfg_tx_len0_i  in  2xTRANS_SIZE  elements per row (linear: total)
cfg_tx_len1_i  in  2xTRANS_SIZE  rows (2D only)
cfg_tx_len2_i  in  2xTRANS_SIZE  row stride in bytes (2D only)
cfg_rx_start_addr_i, cfg_rx_datasize_i, cfg_rx_mode_i, cfg_rx_len0_i, cfg_rx_len1_i, cfg_rx_len2_i  in  as TX, scalar  RX configuration
tx_req_o  out  2  per-TX request
tx_addr_o  out  2xL2_AWIDTH_NOAL  per-TX address
tx_datasize_o  out  2x2  latched datasize
tx_gnt_i  in  2  per-TX grant
rx_req_o  out  1  RX request
rx_addr_o  out  L2_AWIDTH_NOAL  RX address
rx_datasize_o  out  2  latched datasize
rx_gnt_i  in  1  RX grant
busy_o  out  1  high in RUN
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters and latched config registers 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE -> RUN on start_i:
  - Same edge latches all cfg_* inputs; later cfg changes have no effect until the next start.
  - Initialises each channel: row_base = start_addr, col = 0, row = 0.
  - TX0 always enabled; TX1 enabled iff mode[0]; RX enabled iff mode[1].
- Beats per channel: linear = len0; 2D = len0*len1.
  - A disabled channel, or one with a zero beat count, is marked finished at start.
- Requests:
  - Each enabled, unfinished channel asserts req the cycle after start (registered).
  - Address is held stable while req=1 and gnt=0.
  - On req&gnt the channel advances in the same cycle; req stays high with the next address (back-to-back, one beat per cycle max).
  - After the last beat is granted, req drops the next cycle and the channel is finished.
- Address arithmetic, element bytes eb = 1/2/4 per datasize (2 and 3 both = 4):
  - Linear: addr = start + col*eb; col counts up to len0-1.
  - 2D: addr = row_base + col*eb. When col == len0-1 is granted: col <- 0, row <- row+1, row_base <- row_base + len2. Channel finished after row == len1-1 and col == len0-1 are granted.
  - All address sums truncated modulo 2^L2_AWIDTH_NOAL (wrap-around, no error).
- Channels are fully independent; a grant on one does not gate the others. Simultaneous grants on all channels in one cycle are all accepted.
- RUN -> DONE when all three channels are finished. DONE lasts exactly one cycle with done_o=1, then IDLE.
- start_i in RUN or DONE is ignored.
- abort_i in RUN:
  - Next cycle: all req=0 and FSM goes to IDLE.
  - No done pulse; an outstanding ungranted request is dropped.
  - abort_i in IDLE has no effect.
  - abort_i and start_i together in IDLE: start wins.
- busy_o = (state == RUN). datasize outputs are the latched values.
- rst_i mid-operation: immediate return to reset values; no done pulse.

Test Plan:
- Linear TX0 only:
  - Stimulus: mode = 0, tx0 start = 0x100, ds = 2, len0 = 4, gnt tied 1.
  - Response: tx_addr_o[0] = 0x100, 0x104, 0x108, 0x10C on 4 consecutive cycles; tx1/rx req never high; done_o pulses one cycle after the last grant; busy_o low afterwards.
- 2D with backpressure:
  - Stimulus: tx0 mode = 1, start = 0x200, ds = 1, len0 = 2, len1 = 3, len2 = 0x40; gnt low every other cycle.
  - Response: addresses 0x200, 0x202, 0x240, 0x242, 0x280, 0x282; each address held until granted; 6 grants total.
- All channels:
  - Stimulus: mode = 3'b011; TX0 len0 = 3, TX1 len0 = 5, RX len0 = 2, all byte; independent random grants.
  - Response: exactly 3/5/2 grants per channel; done only after the last of the three.
- Zero length and wrap:
  - Zero length stimulus: RX len0 = 0 with mode[1] = 1.
  - Zero length response: RX req never asserted and done is unaffected.
  - Wrap stimulus: tx0 start = 0x7FFE, ds = 2, len0 = 2 (AW = 15).
  - Wrap response: addresses 0x7FFE, then 0x0002.
- Abort and ignored start:
  - Stimulus: abort after 2 of 8 grants; then start with new cfg; a second start during RUN.
  - Response: reqs drop next cycle with no done pulse; the new run uses the new cfg from its first beat; the second start has no effect.
- Config latching and reset:
  - Stimulus: change cfg_tx_start_addr_i mid-run; then assert rst_i mid-run.
  - Response: addresses are unaffected by the cfg change; after rst_i all outputs are 0 immediately and done_o stays 0.
